// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Purpose  : Shared op encodings and FSM state type for shift_sequencer.
// Revision : 1.0
// ============================================================================
package shift_pkg;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer_if
// Purpose  : Two-requester command bus and result bus of shift_sequencer.
// Revision : 1.0
// ============================================================================
interface shift_sequencer_if #(
    parameter int WIDTH = 4
);
    localparam int AMT_W = $clog2(WIDTH);

    logic [1:0]       req;
    logic [1:0]       op0;
    logic [1:0]       op1;
    logic [AMT_W-1:0] amt0;
    logic [AMT_W-1:0] amt1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] result;

    modport master (
        output req, op0, op1, amt0, amt1, data0, data1,
        input  gnt, busy, done, done_id, result
    );

    modport slave (
        input  req, op0, op1, amt0, amt1, data0, data1,
        output gnt, busy, done, done_id, result
    );

endinterface
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_step
// Purpose  : Combinational one-position shifter with direction/fill by op.
// Revision : 1.0
// ============================================================================
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = din;
        case (op)
            OP_LSL:  dout = {din[WIDTH-2:0], 1'b0};
            OP_LSR:  dout = {1'b0, din[WIDTH-1:1]};
            OP_ASR:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
            OP_ROL:  dout = {din[WIDTH-2:0], din[WIDTH-1]};
            default: dout = din;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Round-robin shared iterative shifter for two requesters.
// Revision : 1.0
// ============================================================================
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    shift_sequencer_if.slave bus
);

    localparam int AMT_W = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] step_out;
    logic [1:0]       op_q;
    logic [AMT_W-1:0] cnt;
    logic             id_q;
    logic             last_served;
    logic [1:0]       gnt;
    logic             win;
    logic [WIDTH-1:0] sel_data;
    logic [1:0]       sel_op;
    logic [AMT_W-1:0] sel_amt;
    logic             busy_q;
    logic             done_q;
    logic             done_id_q;
    logic [WIDTH-1:0] result_q;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op   (op_q),
        .din  (operand),
        .dout (step_out)
    );

    // Tie goes to whichever requester was not served most recently.
    always_comb begin
        gnt = 2'b00;
        if (state == S_IDLE && !reset) begin
            case (bus.req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_served ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign win      = gnt[1];
    assign sel_data = win ? bus.data1 : bus.data0;
    assign sel_op   = win ? bus.op1   : bus.op0;
    assign sel_amt  = win ? bus.amt1  : bus.amt0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (gnt != 2'b00)
                    state_nxt = (sel_amt == '0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt == AMT_W'(1))
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            operand     <= '0;
            op_q        <= 2'b00;
            cnt         <= '0;
            id_q        <= 1'b0;
            last_served <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= 1'b0;
            result_q    <= '0;
        end else begin
            busy_q <= (state_nxt != S_IDLE);
            done_q <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (gnt != 2'b00) begin
                        operand     <= sel_data;
                        op_q        <= sel_op;
                        cnt         <= sel_amt;
                        id_q        <= win;
                        last_served <= win;
                        if (sel_amt == '0) begin
                            result_q  <= sel_data;
                            done_id_q <= win;
                        end
                    end
                end
                S_SHIFT: begin
                    operand <= step_out;
                    cnt     <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        result_q  <= step_out;
                        done_id_q <= id_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt     = gnt;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.result  = result_q;

endmodule
`default_nettype wire

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller that shares one single-bit shift stage between two requesters. It accepts a shift command (operand, op, amount) from requester 0 or 1 under round-robin arbitration. The operand is shifted one position per clock until the amount is exhausted, and the result is returned with the winner's ID. It sits beside the ALU, so ALU shift instructions use a cheap iterative path instead of a full barrel shifter.

## Interface
- WIDTH, 4: operand/result width in bits.
- AMT_W, $clog2(WIDTH): shift-amount width. Legal amounts are 0..WIDTH-1.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high. Clears all state and outputs.
- req  input  2  per-requester request. Held high until the matching gnt bit is seen.
- op0, op1  input  2 each  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROL.
- amt0, amt1  input  AMT_W each  shift amount.
- data0, data1  input  WIDTH each  operand.
- gnt  output  2  one-hot grant. Pulses for one cycle; the winner's inputs are sampled on that edge.
- busy  output  1  high from the cycle after a grant through the done cycle.
- done  output  1  one-cycle pulse; result valid.
- done_id  output  1  requester that owns the result.
- result  output  WIDTH  shifted value. Held until the next done.

## Operation
- FSM states:
  - IDLE: a grant is possible.
    - amt==0 → DONE.
    - amt>0 → SHIFT, with cnt=amt.
  - SHIFT: applies one step per cycle and decrements cnt. Goes to DONE when cnt reaches 0 after that cycle's step.
  - DONE: drives done, then returns to IDLE.
- Arbitration happens only in IDLE:
  - Single requester: it wins.
  - Both requesting: the requester not served last wins.
  - The last-served pointer resets to 1, so requester 0 wins the first tie.
  - gnt is combinationally zero outside IDLE.
- Step semantics, one bit per step:
  - LSL: shift left, zero fill at LSB.
  - LSR: shift right, zero fill at MSB.
  - ASR: shift right, MSB replicated.
  - ROL: MSB wraps to LSB.
- Operand, op, amt and ID are registered at the grant. Later changes on the requester's inputs have no effect on an in-flight command.
- result is updated only on the transition into DONE. done_id is updated together with it.
- Boundary cases:
  - amt==0: result equals data.
  - Amounts are ≤ WIDTH-1 by contract, so cnt never wraps.
  - A requester that deasserts req before grant simply loses arbitration; no error is raised.
  - req asserted during SHIFT or DONE waits for IDLE.
- Reset mid-operation (any state): the command is abandoned and no done is issued. The requester must re-request.
- Reset values: state IDLE, gnt=0, busy=0, done=0, done_id=0, result=0, cnt=0, last-served=1.

## Timing
- Grant at edge T, in IDLE.
- busy is high from T+1 through the done cycle.
- done is high in cycle T+amt+1 (amt steps plus one DONE cycle).
- The earliest next grant is at edge T+amt+2, so back-to-back throughput is one command per amt+2 cycles.
- gnt is a Mealy output of the IDLE state and req. All other outputs are registered.

## Structure
- Shared package shift_pkg holds:
  - the op encoding constants (OP_LSL, OP_LSR, OP_ASR, OP_ROL);
  - the FSM state enum (S_IDLE, S_SHIFT, S_DONE).
- Sub-module shift_step: purely combinational, WIDTH-bit one-position shifter selected by op. It generalises the existing 4-bit shifter with direction and fill control.
- The top level contains the FSM, round-robin pointer, operand/op/cnt/ID registers and the result register.

## Test plan
- LSL: req0, data0=0011, amt0=2 → gnt=01 at T; done at T+3 with result=1100, done_id=0.
- ASR: req1, data1=1000, amt1=3 → done at T+4 with result=1111, done_id=1.
- ROL: req0, data0=1001, amt0=1 → result=0011. Repeat with LSR, amt=1 → 0100.
- Zero amount: amt=0, data=1010 → done at T+1 with result=1010, busy high for one cycle.
- Arbitration: both req held continuously, with amt=1 each → grants alternate 01,10,01,…; first grant goes to requester 0; grants are spaced 3 cycles apart.
- Reset during SHIFT (amt=3, reset pulsed at T+2) → no done; all outputs return to 0; the next tie goes to requester 0.
